// File: rtl/nonce_result_checker.sv
// nonce_result_checker
// Captures one batch of NUM_CORES 64-bit digest prefixes and scores them
// against a leading-zero difficulty, one core per cycle. The first passing
// core of a batch is offered to the report stage through a one-entry win slot.
// Passes that cannot be reported are counted in a saturating drop counter.
// Optional best-result tracking is built only when NONCE_BEST_TRACK_EN is defined.
module nonce_result_checker #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     result_valid,
    output logic                     result_ready,
    input  logic [31:0]              nonce_base,
    input  logic [64*NUM_CORES-1:0]  digest_hi,
    input  logic [6:0]               difficulty,
    output logic                     found_valid,
    input  logic                     found_ready,
    output logic [31:0]              found_nonce,
    output logic [63:0]              found_hash,
    output logic [6:0]               found_zeros,
    output logic [15:0]              hits_dropped,
    output logic [CNT_W-1:0]         hash_count,
    output logic [6:0]               best_zeros,
    output logic [31:0]              best_nonce
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic { IDLE = 1'b0, CHECK = 1'b1 } state_t;

    // Leading zero count of a 64-bit word; an all-zero word counts as 64.
    function automatic logic [6:0] lzc64(input logic [63:0] v);
        logic [6:0] n;
        logic       done;
        n    = 7'd0;
        done = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 7'd1;
            end
        end
        return n;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                    state_q;
    logic                      ready_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      batch_hit_q;
    logic                      fv_q;
    logic [31:0]               fn_q;
    logic [63:0]               fh_q;
    logic [6:0]                fz_q;
    logic [15:0]               hits_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [31:0]               nonce_q;
    logic [64*NUM_CORES-1:0]   digest_q;
    logic [6:0]                diff_q;

    logic                      accept_d;
    logic                      last_d;
    logic [63:0]               cur_digest_d;
    logic [6:0]                cur_lz_d;
    logic                      cur_pass_d;
    logic [31:0]               cur_nonce_d;
    logic                      slot_free_d;

    assign accept_d     = result_valid && ready_q && (state_q == IDLE);
    assign last_d       = (idx_q == IDX_W'(NUM_CORES - 1));
    assign cur_digest_d = digest_q[64*int'(idx_q) +: 64];
    assign cur_lz_d     = lzc64(cur_digest_d);
    // Captured difficulty is already clamped to 64, so a zero digest always passes.
    assign cur_pass_d   = (cur_lz_d >= diff_q);
    assign cur_nonce_d  = nonce_q + 32'(idx_q);
    // The slot can take a new win if empty or being drained on this very edge.
    assign slot_free_d  = !fv_q || found_ready;

    // Batch capture; only meaningful after an accept, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            nonce_q  <= nonce_base;
            digest_q <= digest_hi;
            diff_q   <= (difficulty > 7'd64) ? 7'd64 : difficulty;
        end
    end

    // Control FSM plus win slot, drop counter and hash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            batch_hit_q <= 1'b0;
            fv_q        <= 1'b0;
            fn_q        <= '0;
            fh_q        <= '0;
            fz_q        <= '0;
            hits_q      <= '0;
            cnt_q       <= '0;
        end else begin
            if (fv_q && found_ready) fv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        state_q     <= CHECK;
                        ready_q     <= 1'b0;
                        idx_q       <= '0;
                        batch_hit_q <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(NUM_CORES);
                    end
                end
                CHECK: begin
                    if (cur_pass_d) begin
                        batch_hit_q <= 1'b1;
                        if (!batch_hit_q && slot_free_d) begin
                            fv_q <= 1'b1;
                            fn_q <= cur_nonce_d;
                            fh_q <= cur_digest_d;
                            fz_q <= cur_lz_d;
                        end else begin
                            hits_q <= sat_inc16(hits_q);
                        end
                    end
                    if (last_d) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef NONCE_BEST_TRACK_EN
    logic [6:0]  best_z_q;
    logic [31:0] best_n_q;

    // Best result seen so far, independent of difficulty; ties keep the earlier nonce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_z_q <= '0;
            best_n_q <= '0;
        end else if (state_q == CHECK && cur_lz_d > best_z_q) begin
            best_z_q <= cur_lz_d;
            best_n_q <= cur_nonce_d;
        end
    end

    assign best_zeros = best_z_q;
    assign best_nonce = best_n_q;
`else
    assign best_zeros = 7'd0;
    assign best_nonce = 32'd0;
`endif

    assign result_ready = ready_q;
    assign found_valid  = fv_q;
    assign found_nonce  = fn_q;
    assign found_hash   = fh_q;
    assign found_zeros  = fz_q;
    assign hits_dropped = hits_q;
    assign hash_count   = cnt_q;

endmodule

// File: tb/tb_nonce_result_checker.sv
// Directed testbench for nonce_result_checker (NUM_CORES=4, CNT_W=48).
module tb_nonce_result_checker;

    localparam int          NC   = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LZ3  = 64'h1FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LZ9  = 64'h007F_FFFF_FFFF_FFFF;
    localparam logic [63:0] LZ2  = 64'h3FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LZ16 = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] LZ17 = 64'h0000_7FFF_FFFF_FFFF;

`ifdef NONCE_BEST_TRACK_EN
    localparam logic [6:0]  EXP_BZ = 7'd9;
    localparam logic [31:0] EXP_BN = 32'h0000_0301;
`else
    localparam logic [6:0]  EXP_BZ = 7'd0;
    localparam logic [31:0] EXP_BN = 32'd0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            result_valid;
    logic            result_ready;
    logic [31:0]     nonce_base;
    logic [64*NC-1:0] digest_hi;
    logic [6:0]      difficulty;
    logic            found_valid;
    logic            found_ready;
    logic [31:0]     found_nonce;
    logic [63:0]     found_hash;
    logic [6:0]      found_zeros;
    logic [15:0]     hits_dropped;
    logic [47:0]     hash_count;
    logic [6:0]      best_zeros;
    logic [31:0]     best_nonce;

    nonce_result_checker #(.NUM_CORES(NC), .CNT_W(48)) dut (
        .clk(clk), .rst_n(rst_n),
        .result_valid(result_valid), .result_ready(result_ready),
        .nonce_base(nonce_base), .digest_hi(digest_hi), .difficulty(difficulty),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash), .found_zeros(found_zeros),
        .hits_dropped(hits_dropped), .hash_count(hash_count),
        .best_zeros(best_zeros), .best_nonce(best_nonce)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]  nb;
        logic [255:0] dig;
        logic [6:0]   diff;
        logic         drain;
        logic         exp_fv;
        logic [31:0]  exp_nonce;
        logic [6:0]   exp_zeros;
        logic [63:0]  exp_hash;
        logic [15:0]  exp_hits;
        logic [47:0]  exp_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one batch for one edge, then scrambles inputs.
    task automatic accept_batch(input logic [31:0] nb, input logic [255:0] dig, input logic [6:0] diff);
        int w;
        w = 0;
        while (!result_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_before_accept", result_ready, 1);
        nonce_base   = nb;
        digest_hi    = dig;
        difficulty   = diff;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        nonce_base   = 32'hDEAD_BEEF;
        digest_hi    = '0;
        difficulty   = 7'd0;
        chk("ready_low_after_accept", result_ready, 0);
    endtask

    task automatic run_batch(input logic [31:0] nb, input logic [255:0] dig, input logic [6:0] diff);
        accept_batch(nb, dig, diff);
        tick();
        tick();
        tick();
        chk("ready_low_E3", result_ready, 0);
        tick();
        chk("ready_high_E4", result_ready, 1);
    endtask

    task automatic drain();
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        chk("drain_fv", found_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        result_valid = 1'b0;
        nonce_base   = '0;
        digest_hi    = '0;
        difficulty   = '0;
        found_ready  = 1'b0;

        tbl[0] = '{32'h0000_0100, {4{ONES}},                 7'd8,   1'b0, 1'b0, 32'h0,         7'd0,  64'h0, 16'd0, 48'd4};
        tbl[1] = '{32'h0000_0010, {ONES, LZ17, ONES, ONES},  7'd16,  1'b1, 1'b1, 32'h0000_0012, 7'd17, LZ17,  16'd0, 48'd8};
        tbl[2] = '{32'h0000_0020, {4{ONES}},                 7'd0,   1'b0, 1'b1, 32'h0000_0020, 7'd0,  ONES,  16'd3, 48'd12};
        tbl[3] = '{32'h0000_0040, {4{ONES}},                 7'd0,   1'b1, 1'b1, 32'h0000_0020, 7'd0,  ONES,  16'd7, 48'd16};
        tbl[4] = '{32'hFFFF_FFFE, {64'h0, ONES, ONES, ONES}, 7'd64,  1'b1, 1'b1, 32'h0000_0001, 7'd64, 64'h0, 16'd7, 48'd20};
        tbl[5] = '{32'hFFFF_FFFE, {64'h0, ONES, ONES, ONES}, 7'd100, 1'b1, 1'b1, 32'h0000_0001, 7'd64, 64'h0, 16'd7, 48'd24};

        // Reset state
        #22;
        chk("rst_ready", result_ready, 0);
        chk("rst_fv", found_valid, 0);
        chk("rst_cnt", hash_count, 0);
        chk("rst_hits", hits_dropped, 0);
        chk("rst_nonce", found_nonce, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", result_ready, 1);

        // Table-driven batches
        for (int i = 0; i < 6; i++) begin
            run_batch(tbl[i].nb, tbl[i].dig, tbl[i].diff);
            chk($sformatf("v%0d_fv", i), found_valid, tbl[i].exp_fv);
            chk($sformatf("v%0d_nonce", i), found_nonce, tbl[i].exp_nonce);
            chk($sformatf("v%0d_zeros", i), found_zeros, tbl[i].exp_zeros);
            chk($sformatf("v%0d_hash", i), found_hash, tbl[i].exp_hash);
            chk($sformatf("v%0d_hits", i), hits_dropped, tbl[i].exp_hits);
            chk($sformatf("v%0d_cnt", i), hash_count, tbl[i].exp_cnt);
            if (tbl[i].drain) drain();
        end
        chk("best_z_mid", best_zeros, (EXP_BZ == 7'd0) ? 7'd0 : 7'd64);

        // Existing win consumed on the same edge a new pass arrives
        run_batch(32'h0000_0500, {ONES, ONES, ONES, 64'h0}, 7'd16);
        chk("hs_a_fv", found_valid, 1);
        chk("hs_a_nonce", found_nonce, 32'h500);
        accept_batch(32'h0000_0600, {ONES, ONES, LZ16, ONES}, 7'd16);
        tick();
        chk("hs_b_e1_fv", found_valid, 1);
        chk("hs_b_e1_stable", found_nonce, 32'h500);
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        chk("hs_b_fv", found_valid, 1);
        chk("hs_b_nonce", found_nonce, 32'h601);
        chk("hs_b_zeros", found_zeros, 16);
        chk("hs_b_hits", hits_dropped, 7);
        tick();
        tick();
        chk("hs_b_ready", result_ready, 1);
        chk("hs_b_cnt", hash_count, 32);

        // Reset in the middle of a batch with a win held
        accept_batch(32'h0000_0700, {4{ONES}}, 7'd0);
        tick();
        chk("mid_hits", hits_dropped, 8);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fv", found_valid, 0);
        chk("mid_rst_nonce", found_nonce, 0);
        chk("mid_rst_hash", found_hash, 0);
        chk("mid_rst_zeros", found_zeros, 0);
        chk("mid_rst_hits", hits_dropped, 0);
        chk("mid_rst_cnt", hash_count, 0);
        chk("mid_rst_ready", result_ready, 0);
        chk("mid_rst_bestz", best_zeros, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_ready_after", result_ready, 1);

        // Best tracking: lz 3,9,9,2 with nothing passing difficulty 10
        run_batch(32'h0000_0300, {LZ2, LZ9, LZ9, LZ3}, 7'd10);
        chk("best_fv", found_valid, 0);
        chk("best_cnt", hash_count, 4);
        chk("best_hits", hits_dropped, 0);
        chk("best_zeros", best_zeros, EXP_BZ);
        chk("best_nonce", best_nonce, EXP_BN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nonce_result_checker.md
Name: nonce_result_checker

Overview:
- Sits directly downstream of the four parallel double-SHA hash cores in the miner top level.
- Once per nonce batch it captures the top 64 digest bits of each core and checks each core against a programmable leading-zero difficulty, one core per cycle.
- Reports the first winning nonce per batch over a valid/ready handshake to the display/report stage.
- Keeps running statistics: hashes tried and best leading-zero count.

Parameters:
- NUM_CORES, 4, hash cores per batch; core k hashed nonce_base+k (supported values 1..8).
- CNT_W, 48, width of hash_count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- result_valid  input  1  batch digests and nonce_base are valid.
- result_ready  output  1  checker can accept a batch.
- nonce_base  input  32  nonce hashed by core 0.
- digest_hi  input  64*NUM_CORES  core k digest bits {h1,h2} in slice [64k+63:64k]; h1[31] is the MSB.
- difficulty  input  7  required leading zeros, 0..64; values >64 are treated as 64.
- found_valid  output  1  winning nonce held.
- found_ready  input  1  consumer accepts the win.
- found_nonce  output  32  winning nonce.
- found_hash  output  64  winning core's {h1,h2}.
- found_zeros  output  7  leading zeros of found_hash.
- hits_dropped  output  16  passing results not reported; saturates at 0xFFFF.
- hash_count  output  CNT_W  total nonces checked.
- best_zeros  output  7  maximum leading zeros seen (optional feature).
- best_nonce  output  32  nonce that produced best_zeros (optional feature).

Behaviour:
- Reset, asynchronous while rst_n=0: every output register is 0, state is IDLE. result_ready=1 one cycle after rst_n deasserts.
- FSM states: IDLE, CHECK.
- IDLE:
  - result_ready=1.
  - On the posedge where result_valid && result_ready: register nonce_base, all digest_hi slices, and min(difficulty,64). Set idx=0 and go to CHECK.
  - hash_count += NUM_CORES, wrapping modulo 2^CNT_W.
- CHECK:
  - result_ready=0.
  - Each cycle, evaluate captured core idx: lz = leading zero count of its 64-bit slice (64 if the slice is all zero). It passes if lz >= captured difficulty; difficulty 0 means every core passes.
  - If idx==NUM_CORES-1, return to IDLE; otherwise idx += 1.
- Latency: with acceptance at edge E, core k's verdict is registered at edge E+1+k. result_ready is high again after edge E+NUM_CORES.
- Win slot:
  - A pass loads found_* and sets found_valid=1 only if the slot is free: found_valid=0, or found_valid && found_ready on that same edge.
  - Only the first pass in a batch is loaded. Later passes in the same batch increment hits_dropped.
  - A pass that finds the slot still occupied increments hits_dropped. The slot is never overwritten.
- Output handshake:
  - found_valid drops on the edge where found_valid && found_ready, unless a new win loads on that same edge; then it stays 1 with the new data.
  - found_* are stable while found_valid=1 and found_ready=0.
- Inputs are sampled only at acceptance. Changes to nonce_base, digest_hi or difficulty during CHECK have no effect.
- Nonce arithmetic: nonce_base+k wraps modulo 2^32.
- Reset mid-CHECK abandons the batch. Counters and the win slot clear.

Optional Feature:
- Macro: NONCE_BEST_TRACK_EN.
- Defined:
  - During CHECK, if lz > best_zeros, set best_zeros=lz and best_nonce=nonce_base+idx.
  - Strictly greater only: on a tie the first nonce is kept.
  - Difficulty is irrelevant to this tracking.
- Undefined: best_zeros and best_nonce are constant 0 and no tracking registers are built.

Test Plan:
- Reset release, then batch nonce_base=0x100, all digests 0xFFFF..., difficulty=8 -> after 4 CHECK cycles: found_valid=0, hash_count=4, hits_dropped=0; result_ready back high at E+4.
- difficulty=16; core2 slice=0x00007FFF_FFFFFFFF; others all-ones; nonce_base=0x10 -> found_valid rises after edge E+3 with found_nonce=0x12, found_zeros=17, found_hash=0x00007FFF_FFFFFFFF.
- difficulty=0, found_ready=0, nonce_base=0x20 -> found_nonce=0x20, hits_dropped=3. A second batch gives hits_dropped=7 and found_nonce still 0x20.
- Pass at core1 with found_ready=1 asserted on the same edge as an existing win is consumed -> new found_nonce loads, found_valid stays 1, hits_dropped unchanged.
- nonce_base=0xFFFFFFFE, difficulty=64, core3 slice all zero -> found_nonce=0x00000001, found_zeros=64. difficulty=100 behaves identically.
- rst_n pulsed low mid-CHECK with found_valid=1 -> all outputs 0 immediately. With NONCE_BEST_TRACK_EN: lz sequence 3,9,9,2 gives best_zeros=9 and best_nonce=nonce_base+1.
